// File: rtl/operand_fetch.sv
// operand_fetch -- register-operand fetch stage with a pending-write scoreboard.
//
// An instruction presents its two source addresses, which go straight to the
// register file read ports. The operands that come back are captured, together
// with the destination address, write enable and opaque payload, in a single
// output register. The output register uses a valid/ready handshake on both
// sides and adds exactly one cycle of latency.
//
// The scoreboard holds one pending bit per register:
//   - an accepted instruction that writes rd sets pending[rd];
//   - a writeback clears pending[wb_addr];
//   - a set and a clear of the same register in one cycle leave the bit set.
// A source whose pending bit is set stalls the input until the bit clears.
// Register 0 is hard-wired to zero and is never pending.
//
// Build option:
//   OPF_BYPASS_EN - a source that matches the writeback in flight this cycle
//                   takes wb_data_i directly and does not stall. Without it,
//                   the source stalls until the cycle after the clear and then
//                   reads the register file.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   in_*                     upstream instruction (valid/ready handshake)
//   rf_rs1/2_addr_o          register file read addresses (combinational)
//   rf_rs1/2_i               register file read data (combinational)
//   wb_we_i/addr_i/data_i    writeback from later stages
//   out_*                    downstream operands (valid/ready handshake)

module operand_fetch #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_REGISTER = 32,
  localparam int AW = $clog2(NUM_REGISTER)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [AW-1:0]         in_rs1_addr_i,
  input  logic [AW-1:0]         in_rs2_addr_i,
  input  logic [AW-1:0]         in_rd_addr_i,
  input  logic                  in_rd_we_i,
  input  logic [DATA_WIDTH-1:0] in_payload_i,
  output logic [AW-1:0]         rf_rs1_addr_o,
  output logic [AW-1:0]         rf_rs2_addr_o,
  input  logic [DATA_WIDTH-1:0] rf_rs1_i,
  input  logic [DATA_WIDTH-1:0] rf_rs2_i,
  input  logic                  wb_we_i,
  input  logic [AW-1:0]         wb_addr_i,
  input  logic [DATA_WIDTH-1:0] wb_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_rs1_o,
  output logic [DATA_WIDTH-1:0] out_rs2_o,
  output logic [AW-1:0]         out_rd_addr_o,
  output logic                  out_rd_we_o,
  output logic [DATA_WIDTH-1:0] out_payload_o
);

  localparam logic [AW-1:0]           ZERO_ADDR = {AW{1'b0}};
  localparam logic [DATA_WIDTH-1:0]   ZERO_DATA = {DATA_WIDTH{1'b0}};
  localparam logic [NUM_REGISTER-1:0] ZERO_MASK = {NUM_REGISTER{1'b0}};

  // A source stalls when it names a real register that still awaits a write,
  // unless the write is being forwarded this very cycle.
  function automatic logic src_hazard(input logic [AW-1:0] addr,
                                      input logic          pend,
                                      input logic          bypass_hit);
    return (addr != ZERO_ADDR) && pend && !bypass_hit;
  endfunction

  // Operand selection: register 0 reads as zero, a forwarded write beats the
  // (stale) register file value.
  function automatic logic [DATA_WIDTH-1:0] pick_operand(input logic [AW-1:0]         addr,
                                                         input logic                  bypass_hit,
                                                         input logic [DATA_WIDTH-1:0] rf_data,
                                                         input logic [DATA_WIDTH-1:0] wb_data);
    if (addr == ZERO_ADDR) begin
      return ZERO_DATA;
    end else if (bypass_hit) begin
      return wb_data;
    end else begin
      return rf_data;
    end
  endfunction

  logic [NUM_REGISTER-1:0] pending;
  logic [NUM_REGISTER-1:0] pending_next;
  logic [NUM_REGISTER-1:0] set_mask;
  logic [NUM_REGISTER-1:0] clr_mask;
  logic                    byp_rs1;
  logic                    byp_rs2;
  logic                    haz_rs1;
  logic                    haz_rs2;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   opnd_rs1;
  logic [DATA_WIDTH-1:0]   opnd_rs2;

  assign rf_rs1_addr_o = in_rs1_addr_i;
  assign rf_rs2_addr_o = in_rs2_addr_i;

`ifdef OPF_BYPASS_EN
  assign byp_rs1 = wb_we_i && (wb_addr_i != ZERO_ADDR) && (wb_addr_i == in_rs1_addr_i);
  assign byp_rs2 = wb_we_i && (wb_addr_i != ZERO_ADDR) && (wb_addr_i == in_rs2_addr_i);
`else
  assign byp_rs1 = 1'b0;
  assign byp_rs2 = 1'b0;
`endif

  assign haz_rs1    = src_hazard(in_rs1_addr_i, pending[in_rs1_addr_i], byp_rs1);
  assign haz_rs2    = src_hazard(in_rs2_addr_i, pending[in_rs2_addr_i], byp_rs2);
  assign in_ready_o = (!out_valid_o || out_ready_i) && !haz_rs1 && !haz_rs2;
  assign accept     = in_valid_i && in_ready_o;

  assign opnd_rs1 = pick_operand(in_rs1_addr_i, byp_rs1, rf_rs1_i, wb_data_i);
  assign opnd_rs2 = pick_operand(in_rs2_addr_i, byp_rs2, rf_rs2_i, wb_data_i);

  // Scoreboard next state: clear from writeback, then set from the accepted
  // instruction so that a same-register set overrides the clear.
  always_comb begin
    set_mask = ZERO_MASK;
    clr_mask = ZERO_MASK;
    if (accept && in_rd_we_i && (in_rd_addr_i != ZERO_ADDR)) begin
      set_mask[in_rd_addr_i] = 1'b1;
    end else begin
      set_mask = ZERO_MASK;
    end
    if (wb_we_i && (wb_addr_i != ZERO_ADDR)) begin
      clr_mask[wb_addr_i] = 1'b1;
    end else begin
      clr_mask = ZERO_MASK;
    end
    pending_next    = (pending & ~clr_mask) | set_mask;
    pending_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending <= ZERO_MASK;
    end else begin
      pending <= pending_next;
    end
  end

  // Output register: load on accept, empty when drained, otherwise hold.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o   <= 1'b0;
      out_rs1_o     <= ZERO_DATA;
      out_rs2_o     <= ZERO_DATA;
      out_rd_addr_o <= ZERO_ADDR;
      out_rd_we_o   <= 1'b0;
      out_payload_o <= ZERO_DATA;
    end else if (accept) begin
      out_valid_o   <= 1'b1;
      out_rs1_o     <= opnd_rs1;
      out_rs2_o     <= opnd_rs2;
      out_rd_addr_o <= in_rd_addr_i;
      out_rd_we_o   <= in_rd_we_i;
      out_payload_o <= in_payload_i;
    end else if (out_ready_i) begin
      out_valid_o   <= 1'b0;
    end else begin
      out_valid_o   <= out_valid_o;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: reset values, a table of single-cycle
// fetches, hand-written hazard / backpressure / reset sequences and a random
// run, all compared against a behavioural model of the stage.
module tb_operand_fetch;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

`ifdef OPF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_rs1, in_rs2, in_rd;
  logic          in_rd_we;
  logic [DW-1:0] in_payload;
  logic [AW-1:0] rf_rs1_addr, rf_rs2_addr;
  logic [DW-1:0] rf_rs1, rf_rs2;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_rs1, out_rs2, out_payload;
  logic [AW-1:0] out_rd;
  logic          out_rd_we;

  logic [DW-1:0] rf_mem [NR];

  always #5 clk = ~clk;

  assign rf_rs1 = rf_mem[rf_rs1_addr];
  assign rf_rs2 = rf_mem[rf_rs2_addr];

  operand_fetch #(.DATA_WIDTH(DW), .NUM_REGISTER(NR)) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_rs1_addr_i(in_rs1), .in_rs2_addr_i(in_rs2), .in_rd_addr_i(in_rd),
    .in_rd_we_i(in_rd_we), .in_payload_i(in_payload),
    .rf_rs1_addr_o(rf_rs1_addr), .rf_rs2_addr_o(rf_rs2_addr),
    .rf_rs1_i(rf_rs1), .rf_rs2_i(rf_rs2),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_rs1_o(out_rs1), .out_rs2_o(out_rs2), .out_rd_addr_o(out_rd),
    .out_rd_we_o(out_rd_we), .out_payload_o(out_payload)
  );

  // Behavioural model: set of registers awaiting a write, plus the one-deep
  // output slot.
  bit            m_pend [NR];
  bit            m_valid;
  logic [DW-1:0] m_rs1, m_rs2, m_pay;
  logic [AW-1:0] m_rd;
  bit            m_we;

  int n_checks = 0;
  int n_fail   = 0;
  bit seen_ready;

  typedef struct {
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [DW-1:0] pay;
    logic [DW-1:0] e1;
    logic [DW-1:0] e2;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit fwd(input logic [AW-1:0] a);
    return BYP && wb_we && (wb_addr == a) && (a != 0);
  endfunction

  function automatic bit haz(input logic [AW-1:0] a);
    return (a != 0) && m_pend[a] && !fwd(a);
  endfunction

  function automatic logic [DW-1:0] opnd(input logic [AW-1:0] a);
    if (a == 0) return 32'h0;
    if (fwd(a)) return wb_data;
    return rf_mem[a];
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
    in_payload = 32'h0; wb_we = 1'b0; wb_addr = '0; wb_data = 32'h0;
  endtask

  task automatic issue(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                       input logic [AW-1:0] rd, input logic we, input logic [DW-1:0] pay);
    in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we; in_payload = pay;
  endtask

  // One clock: check readiness against the model mid-cycle, advance the model
  // at the edge, then check the registered outputs just after it.
  task automatic cycle();
    bit            exp_r, acc;
    logic [DW-1:0] n1, n2;
    @(negedge clk);
    seen_ready = in_ready;
    exp_r = (!m_valid || out_ready) && !haz(in_rs1) && !haz(in_rs2);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_r});
    acc = in_valid && exp_r;
    n1  = opnd(in_rs1);
    n2  = opnd(in_rs2);
    @(posedge clk);
    if (wb_we && wb_addr != 0) m_pend[wb_addr] = 1'b0;
    if (acc && in_rd_we && in_rd != 0) m_pend[in_rd] = 1'b1;
    if (acc) begin
      m_valid = 1'b1; m_rs1 = n1; m_rs2 = n2; m_rd = in_rd; m_we = in_rd_we; m_pay = in_payload;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    if (wb_we && wb_addr != 0) rf_mem[wb_addr] = wb_data;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    if (m_valid) begin
      chk("out_rs1", {32'd0, out_rs1}, {32'd0, m_rs1});
      chk("out_rs2", {32'd0, out_rs2}, {32'd0, m_rs2});
      chk("out_rd", {59'd0, out_rd}, {59'd0, m_rd});
      chk("out_rd_we", {63'd0, out_rd_we}, {63'd0, m_we});
      chk("out_payload", {32'd0, out_payload}, {32'd0, m_pay});
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd0);
    chk({tag, "_rs1"}, {32'd0, out_rs1}, 64'd0);
    chk({tag, "_rs2"}, {32'd0, out_rs2}, 64'd0);
    chk({tag, "_rd"}, {59'd0, out_rd}, 64'd0);
    chk({tag, "_rd_we"}, {63'd0, out_rd_we}, 64'd0);
    chk({tag, "_payload"}, {32'd0, out_payload}, 64'd0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf_mem[i] = 32'hA500_0000 | 32'(i);
    rf_mem[0] = 32'hFFFF_FFFF;
    idle();
    out_ready = 1'b1;
    model_reset();
    rst = 1'b1;

    // Reset state.
    #12;
    chk_cleared("reset");
    @(negedge clk);
    rst = 1'b0;

    // Table of independent single-cycle fetches (no writers, no hazards).
    tbl[0] = '{rs1: 5'd3,  rs2: 5'd4,  pay: 32'h11, e1: 32'hA500_0003, e2: 32'hA500_0004};
    tbl[1] = '{rs1: 5'd0,  rs2: 5'd0,  pay: 32'h22, e1: 32'h0,         e2: 32'h0};
    tbl[2] = '{rs1: 5'd31, rs2: 5'd1,  pay: 32'h33, e1: 32'hA500_001F, e2: 32'hA500_0001};
    tbl[3] = '{rs1: 5'd0,  rs2: 5'd17, pay: 32'h44, e1: 32'h0,         e2: 32'hA500_0011};
    tbl[4] = '{rs1: 5'd12, rs2: 5'd0,  pay: 32'h55, e1: 32'hA500_000C, e2: 32'h0};
    tbl[5] = '{rs1: 5'd30, rs2: 5'd30, pay: 32'h66, e1: 32'hA500_001E, e2: 32'hA500_001E};
    for (int i = 0; i < 6; i++) begin
      issue(tbl[i].rs1, tbl[i].rs2, 5'd0, 1'b0, tbl[i].pay);
      cycle();
      chk("tbl_ready", {63'd0, seen_ready}, 64'd1);
      chk("tbl_rs1", {32'd0, out_rs1}, {32'd0, tbl[i].e1});
      chk("tbl_rs2", {32'd0, out_rs2}, {32'd0, tbl[i].e2});
      chk("tbl_payload", {32'd0, out_payload}, {32'd0, tbl[i].pay});
    end
    idle();
    cycle();

    // RAW hazard on r5, resolved by a writeback.
    issue(5'd0, 5'd0, 5'd5, 1'b1, 32'h26);
    cycle();
    issue(5'd5, 5'd0, 5'd0, 1'b0, 32'h27);
    cycle();
    chk("raw_stall", {63'd0, seen_ready}, 64'd0);
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hDEAD_BEEF;
    cycle();
`ifdef OPF_BYPASS_EN
    chk("bypass_accept", {63'd0, seen_ready}, 64'd1);
    chk("bypass_data", {32'd0, out_rs1}, 64'hDEAD_BEEF);
`else
    chk("nobyp_stall", {63'd0, seen_ready}, 64'd0);
    wb_we = 1'b0;
    cycle();
    chk("nobyp_accept", {63'd0, seen_ready}, 64'd1);
    chk("nobyp_data", {32'd0, out_rs1}, 64'hDEAD_BEEF);
`endif
    idle();
    cycle();

    // Backpressure: output held for 3 cycles, then next instruction accepted.
    out_ready = 1'b0;
    issue(5'd2, 5'd3, 5'd0, 1'b0, 32'hA);
    cycle();
    issue(5'd6, 5'd0, 5'd0, 1'b0, 32'hB);
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_ready", {63'd0, seen_ready}, 64'd0);
      chk("hold_payload", {32'd0, out_payload}, 64'hA);
      chk("hold_rs1", {32'd0, out_rs1}, 64'hA500_0002);
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", {63'd0, seen_ready}, 64'd1);
    chk("release_payload", {32'd0, out_payload}, 64'hB);
    idle();
    cycle();

    // Set and clear of r7 in the same cycle: the set must survive.
    issue(5'd0, 5'd0, 5'd7, 1'b1, 32'h29);
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    cycle();
    wb_we = 1'b0;
    issue(5'd7, 5'd0, 5'd0, 1'b0, 32'h2A);
    cycle();
    chk("set_wins", {63'd0, seen_ready}, 64'd0);
    idle();
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h78;
    cycle();
    idle();
    cycle();

    // Four hazard-free instructions back to back.
    for (int i = 0; i < 4; i++) begin
      issue(5'(i + 1), 5'd0, 5'd0, 1'b0, 32'h300 + 32'(i));
      cycle();
      chk("stream_ready", {63'd0, seen_ready}, 64'd1);
      chk("stream_valid", {63'd0, out_valid}, 64'd1);
      chk("stream_payload", {32'd0, out_payload}, {32'd0, 32'h300 + 32'(i)});
    end
    idle();
    cycle();
    chk("stream_drain", {63'd0, out_valid}, 64'd0);

    // Reset pulse while an output is held and r9 is pending.
    out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd9, 1'b1, 32'h25);
    cycle();
    idle();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk_cleared("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    issue(5'd9, 5'd9, 5'd0, 1'b0, 32'h250);
    cycle();
    chk("post_reset_ready", {63'd0, seen_ready}, 64'd1);
    idle();
    cycle();

    // Random traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      in_valid   = 1'($urandom_range(0, 1));
      in_rs1     = 5'($urandom_range(0, 7));
      in_rs2     = 5'($urandom_range(0, 7));
      in_rd      = 5'($urandom_range(0, 7));
      in_rd_we   = 1'($urandom_range(0, 1));
      in_payload = $urandom;
      out_ready  = ($urandom_range(0, 3) != 0);
      wb_we      = ($urandom_range(0, 2) == 0);
      wb_addr    = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
